idct_transpose_buf: RTL and testbench

- Sits between the row-IDCT stage and the column-IDCT stage of the 8x8 inverse DCT path.
- Collects 8 row-IDCT result rows (8 signed words each) into a ping-pong buffer of two banks, 64 words per bank.
- Emits the block column by column, with each column's words permuted into the even/odd input order the column IDCT expects.
- Uses valid/ready handshakes on both sides, so row and column stages can stall independently.

---
 rtl/idct_transpose_buf_pkg.sv | 17 +
 rtl/idct_tbuf_bank.sv | 30 +++
 rtl/idct_transpose_buf.sv | 102 ++++++++++
 tb/tb_idct_transpose_buf.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_transpose_buf_pkg.sv
// Shared constants for the 8x8 inverse-DCT path.
package idct_transpose_buf_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned BLK   = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ROW_W = BLK * W;

  // Column-IDCT slot order: slot j takes row COL_PERM[j] (0,4,6,2,1,7,5,3); slot j at bits [3j+2:3j].
  localparam logic [BLK*IDX_W-1:0] COL_PERM = {3'd3, 3'd5, 3'd7, 3'd1, 3'd2, 3'd6, 3'd4, 3'd0};

  // Row index that feeds a given output slot.
  function automatic logic [IDX_W-1:0] col_perm(input logic [IDX_W-1:0] slot);
    return COL_PERM[IDX_W*int'(slot) +: IDX_W];
  endfunction

endpackage

// File: rtl/idct_tbuf_bank.sv
// One 8x8 bank of W-bit words: row-wide write, permuted column-wide read.
module idct_tbuf_bank
  import idct_transpose_buf_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [ROW_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_col,
  output logic [ROW_W-1:0] rd_data_c
);

  logic [ROW_W-1:0] mem [BLK];

  // Store a full row; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Gather one column with its words reordered into column-IDCT slot order.
  always_comb begin
    rd_data_c = '0;
    for (int j = 0; j < BLK; j++) begin
      rd_data_c[W*j +: W] = mem[col_perm(IDX_W'(j))][W*int'(rd_col) +: W];
    end
  end

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong transpose buffer between the row-IDCT and column-IDCT stages.
module idct_transpose_buf
  import idct_transpose_buf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_data,
  output logic             out_last
);

  logic [1:0]       bank_full;
  logic [1:0]       bank_full_nxt;
  logic             wr_bank;
  logic             wr_bank_nxt;
  logic             rd_bank;
  logic             rd_bank_nxt;
  logic [IDX_W-1:0] row_cnt;
  logic [IDX_W-1:0] col_cnt;
  logic             wr_fire_c;
  logic             rd_fire_c;
  logic             wr_last_c;
  logic             rd_last_c;
  logic [ROW_W-1:0] rd_data0_c;
  logic [ROW_W-1:0] rd_data1_c;
  logic [ROW_W-1:0] col_data_c;

  assign wr_fire_c  = in_valid && in_ready;
  assign rd_fire_c  = (!out_valid || out_ready) && bank_full[rd_bank];
  assign wr_last_c  = wr_fire_c && (row_cnt == IDX_W'(BLK - 1));
  assign rd_last_c  = rd_fire_c && (col_cnt == IDX_W'(BLK - 1));
  assign col_data_c = rd_bank ? rd_data1_c : rd_data0_c;

  idct_tbuf_bank u_bank0 (
    .clk       (clk),
    .wr_en     (wr_fire_c && !wr_bank),
    .wr_row    (row_cnt),
    .wr_data   (in_data),
    .rd_col    (col_cnt),
    .rd_data_c (rd_data0_c)
  );

  idct_tbuf_bank u_bank1 (
    .clk       (clk),
    .wr_en     (wr_fire_c && wr_bank),
    .wr_row    (row_cnt),
    .wr_data   (in_data),
    .rd_col    (col_cnt),
    .rd_data_c (rd_data1_c)
  );

  // Bank fill/release bookkeeping; fill and release always target different banks.
  always_comb begin
    bank_full_nxt = bank_full;
    wr_bank_nxt   = wr_bank;
    rd_bank_nxt   = rd_bank;
    if (wr_last_c) begin
      bank_full_nxt[wr_bank] = 1'b1;
      wr_bank_nxt            = !wr_bank;
    end
    if (rd_last_c) begin
      bank_full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt            = !rd_bank;
    end
  end

  // Pointers, counters, registered in_ready and the output column register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      row_cnt   <= '0;
      col_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_bank   <= rd_bank_nxt;
      in_ready  <= !bank_full_nxt[wr_bank_nxt];
      if (wr_fire_c) begin
        row_cnt <= row_cnt + IDX_W'(1);
      end
      if (rd_fire_c) begin
        col_cnt  <= col_cnt + IDX_W'(1);
        out_data <= col_data_c;
      end
      if (!out_valid || out_ready) begin
        out_valid <= bank_full[rd_bank];
        out_last  <= rd_last_c;
      end
    end
  end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Self-checking bench for idct_transpose_buf: scoreboard plus table and corner sequences.
module tb_idct_transpose_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         out_last;

  always #5 clk = ~clk;

  idct_transpose_buf dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef struct {
    logic [255:0] data;
    logic         last;
  } col_t;

  typedef struct {
    int          col;
    int          slot;
    logic [31:0] exp;
    logic        last;
  } vec_t;

  col_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [255:0] mrow [8];
  int           mrow_cnt = 0;
  int           perm [8];

  logic         s_ir, s_ov, s_ol;
  logic [255:0] s_od;
  bit           in_fire, out_fire;
  bit           have_hold = 0;
  logic [255:0] hold_d;
  logic         hold_l;
  bit           cap_en = 0;
  int           cap_n = 0;
  logic [255:0] cap_d [8];
  logic         cap_l [8];
  bit           neg_chk = 0;
  int           popped = 0;
  bit           bubble_trk = 0;
  int           bubbles = 0;
  vec_t         vt [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkrow(input int base, input int r);
    logic [255:0] v;
    for (int c = 0; c < 8; c++) v[32*c +: 32] = 32'(base + 100*r + c);
    return v;
  endfunction

  // Model: transpose and permute a completed block into 8 expected columns.
  task automatic push_block();
    col_t e;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 8; j++) e.data[32*j +: 32] = mrow[perm[j]][32*c +: 32];
      e.last = (c == 7);
      sb.push_back(e);
    end
  endtask

  // One cycle: drive at negedge, sample mid-low-phase, update scoreboard, then let the edge happen.
  task automatic step(input logic iv, input logic [255:0] d, input logic ordy);
    col_t e;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #2;
    s_ir = in_ready; s_ov = out_valid; s_ol = out_last; s_od = out_data;
    in_fire  = iv && s_ir;
    out_fire = s_ov && ordy;
    if (have_hold) begin
      check("stall valid", 256'(s_ov), 256'(1));
      check("stall data", s_od, hold_d);
      check("stall last", 256'(s_ol), 256'(hold_l));
    end
    have_hold = s_ov && !ordy;
    hold_d = s_od;
    hold_l = s_ol;
    if (bubble_trk && !s_ov && popped > 0 && sb.size() > 0) bubbles++;
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("unexpected column", 256'(1), 256'(0));
      end else begin
        e = sb.pop_front();
        check("column data", s_od, e.data);
        check("column last", 256'(s_ol), 256'(e.last));
      end
      if (neg_chk) check("negative slots", s_od, {8{32'hFFFFF800}});
      if (cap_en && cap_n < 8) begin
        cap_d[cap_n] = s_od;
        cap_l[cap_n] = s_ol;
        cap_n++;
      end
      popped++;
    end
    if (in_fire) begin
      mrow[mrow_cnt] = d;
      mrow_cnt++;
      if (mrow_cnt == 8) begin
        push_block();
        mrow_cnt = 0;
      end
    end
  endtask

  task automatic send_rows(input int n, input int base, input logic ordy, input bit neg);
    int r = 0;
    int g = 0;
    while (r < n && g < 200) begin
      step(1'b1, neg ? {8{32'hFFFFF800}} : mkrow(base, r), ordy);
      if (in_fire) r++;
      g++;
    end
    check("rows accepted", 256'(r), 256'(n));
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 300) begin
      step(1'b0, '0, 1'b1);
      g++;
    end
    check("scoreboard drained", 256'(sb.size()), 256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2;
    check("reset in_ready", 256'(in_ready), 256'(1));
    check("reset out_valid", 256'(out_valid), 256'(0));
    check("reset out_last", 256'(out_last), 256'(0));
    check("reset out_data", out_data, 256'(0));
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    mrow_cnt  = 0;
    have_hold = 0;
  endtask

  initial begin
    int p0, g, hs, r;
    perm = '{0, 4, 6, 2, 1, 7, 5, 3};
    vt[0]  = '{0, 0, 32'd0,   1'b0}; vt[1]  = '{0, 1, 32'd400, 1'b0};
    vt[2]  = '{0, 2, 32'd600, 1'b0}; vt[3]  = '{0, 3, 32'd200, 1'b0};
    vt[4]  = '{0, 4, 32'd100, 1'b0}; vt[5]  = '{0, 5, 32'd700, 1'b0};
    vt[6]  = '{0, 6, 32'd500, 1'b0}; vt[7]  = '{0, 7, 32'd300, 1'b0};
    vt[8]  = '{7, 0, 32'd7,   1'b1}; vt[9]  = '{7, 1, 32'd407, 1'b1};
    vt[10] = '{7, 2, 32'd607, 1'b1}; vt[11] = '{7, 3, 32'd207, 1'b1};
    vt[12] = '{7, 4, 32'd107, 1'b1}; vt[13] = '{7, 5, 32'd707, 1'b1};
    vt[14] = '{7, 6, 32'd507, 1'b1}; vt[15] = '{7, 7, 32'd307, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    do_reset();

    // Block fill and readout with latency check and table compare.
    cap_en = 1; cap_n = 0;
    send_rows(8, 0, 1'b1, 0);
    step(1'b0, '0, 1'b1);
    check("latency not early", 256'(s_ov), 256'(0));
    step(1'b0, '0, 1'b1);
    check("latency out_valid", 256'(s_ov), 256'(1));
    drain();
    cap_en = 0;
    check("captured columns", 256'(cap_n), 256'(8));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("table col%0d slot%0d", vt[i].col, vt[i].slot),
            256'(cap_d[vt[i].col][32*vt[i].slot +: 32]), 256'(vt[i].exp));
      check($sformatf("table col%0d last", vt[i].col), 256'(cap_l[vt[i].col]), 256'(vt[i].last));
    end
    for (int c = 0; c < 8; c++) check($sformatf("last flag col%0d", c), 256'(cap_l[c]), 256'(c == 7));

    // Double-buffer backpressure.
    send_rows(16, 1000, 1'b0, 0);
    step(1'b1, mkrow(1000, 16), 1'b0);
    check("in_ready both full", 256'(s_ir), 256'(0));
    check("17th row refused", 256'(in_fire), 256'(0));
    hs = 0; g = 0;
    while (hs < 8 && g < 50) begin
      step(1'b0, '0, 1'b1);
      if (out_fire) hs++;
      g++;
    end
    check("backpressure handshakes", 256'(hs), 256'(8));
    step(1'b0, '0, 1'b0);
    check("in_ready after release", 256'(s_ir), 256'(1));
    drain();

    // Output stall with out_ready pattern 1,0,0,1.
    send_rows(8, 2000, 1'b0, 0);
    g = 0;
    while (sb.size() > 0 && g < 200) begin
      step(1'b0, '0, (g % 4 == 0) || (g % 4 == 3));
      g++;
    end
    drain();

    // Negative values pass through.
    neg_chk = 1;
    send_rows(8, 0, 1'b1, 1);
    drain();
    neg_chk = 0;

    // Reset after row 3, then during column 2 readout.
    send_rows(4, 3000, 1'b0, 0);
    do_reset();
    send_rows(8, 4000, 1'b1, 0);
    p0 = popped; g = 0;
    while (popped - p0 < 2 && g < 50) begin
      step(1'b0, '0, 1'b1);
      g++;
    end
    check("reached column 2", 256'(popped - p0), 256'(2));
    do_reset();
    send_rows(8, 5000, 1'b1, 0);
    drain();

    // Streaming: 4 blocks back to back, both sides ready.
    bubble_trk = 1; bubbles = 0; p0 = popped; popped = 0; r = 0; g = 0;
    while (popped < 32 && g < 300) begin
      step(r < 32, mkrow(6000 + 1000*(r/8), r % 8), 1'b1);
      if (in_fire) r++;
      g++;
    end
    bubble_trk = 0;
    check("stream rows in", 256'(r), 256'(32));
    check("stream columns out", 256'(popped), 256'(32));
    check("stream bubbles", 256'(bubbles), 256'(0));
    check("stream scoreboard empty", 256'(sb.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
